// File: rtl/display_stream_buffer.sv
// display_stream_buffer
// First-word-fall-through pixel FIFO between a pixel producer and a display
// sink. The output side keeps a raster position (x, y) for the head pixel and
// decodes start-of-frame / end-of-line / end-of-frame tags from it. A frame
// index toggles each time the last pixel of a frame is popped. A synchronous
// flush empties the FIFO and re-aligns the raster to the top-left corner.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high in the cycle before it. A valid source holds its data stable
// until accepted. Neither ready nor valid here depends combinationally on the
// opposite side's valid/ready: both come from the registered level and flush_i.
module display_stream_buffer #(
    parameter int PIXEL_W = 24,
    parameter int DEPTH   = 16,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [PIXEL_W-1:0]         s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [PIXEL_W-1:0]         m_data_o,
    output logic                       m_sof_o,
    output logic                       m_eol_o,
    output logic                       m_eof_o,
    output logic                       frame_idx_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    input  logic                       flush_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    // Raster counters need at least one bit even for a 1-pixel dimension.
    localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);

    // Pixel storage (not reset; contents are only meaningful below level_q).
    logic [PIXEL_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [X_W-1:0]   x_q,      x_d;
    logic [Y_W-1:0]   y_q,      y_d;
    logic             frame_q,  frame_d;

    logic push;
    logic pop;
    logic at_x_last;
    logic at_y_last;

    // Handshake qualifiers: flush blocks both sides for the whole cycle.
    always_comb begin
        s_ready_o = (level_q < LVL_FULL) && !flush_i;
        m_valid_o = (level_q != '0) && !flush_i;
        push      = s_valid_i && s_ready_o;
        pop       = m_valid_o && m_ready_i;
    end

    // Head pixel and raster tags, all gated by m_valid_o.
    always_comb begin
        at_x_last   = (x_q == X_LAST);
        at_y_last   = (y_q == Y_LAST);
        m_data_o    = mem_q[rd_ptr_q];
        m_sof_o     = m_valid_o && (x_q == '0) && (y_q == '0);
        m_eol_o     = m_valid_o && at_x_last;
        m_eof_o     = m_valid_o && at_x_last && at_y_last;
        level_o     = level_q;
        frame_idx_o = frame_q;
    end

    // Next-state for pointers, level and raster position.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        x_d      = x_q;
        y_d      = y_q;
        frame_d  = frame_q;

        if (flush_i) begin
            // Drop contents and re-align raster; frame index is preserved.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            x_d      = '0;
            y_d      = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            // Raster advances only when the head pixel leaves.
            if (pop) begin
                if (at_x_last) begin
                    x_d = '0;
                    if (at_y_last) begin
                        y_d     = '0;
                        frame_d = ~frame_q;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

`ifndef SYNTHESIS
    // Occupancy never exceeds the buffer size.
    a_level_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
        level_q <= LVL_FULL);
    // Pop from an empty buffer is impossible.
    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rstn_i)
        pop |-> (level_q != '0));
`endif

endmodule

// File: tb/tb_display_stream_buffer.sv
// Directed bench for display_stream_buffer: a 4x2 raster / depth-4 instance
// for the main scenarios and a 1x1 raster instance for the degenerate case.
module tb_display_stream_buffer;

  logic clk;
  logic rstn;

  // Instance A: H_RES=4, V_RES=2, DEPTH=4
  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_flush;
  logic [23:0] a_s_data, a_m_data;
  logic        a_sof, a_eol, a_eof, a_frame;
  logic [2:0]  a_level;

  // Instance B: H_RES=1, V_RES=1, DEPTH=4
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_flush;
  logic [23:0] b_s_data, b_m_data;
  logic        b_sof, b_eol, b_eof, b_frame;
  logic [2:0]  b_level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] exp_q[$];

  display_stream_buffer #(.PIXEL_W(24), .DEPTH(4), .H_RES(4), .V_RES(2)) dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .s_valid_i(a_s_valid), .s_ready_o(a_s_ready), .s_data_i(a_s_data),
    .m_valid_o(a_m_valid), .m_ready_i(a_m_ready), .m_data_o(a_m_data),
    .m_sof_o(a_sof), .m_eol_o(a_eol), .m_eof_o(a_eof),
    .frame_idx_o(a_frame), .level_o(a_level), .flush_i(a_flush)
  );

  display_stream_buffer #(.PIXEL_W(24), .DEPTH(4), .H_RES(1), .V_RES(1)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data),
    .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_data_o(b_m_data),
    .m_sof_o(b_sof), .m_eol_o(b_eol), .m_eof_o(b_eof),
    .frame_idx_o(b_frame), .level_o(b_level), .flush_i(b_flush)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0; a_flush = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0; b_flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_s_valid = 1'($urandom_range(0, 1));
      a_s_data  = 24'($urandom_range(0, 24'hFFFFFF));
      a_m_ready = 1'($urandom_range(0, 1));
      a_flush   = 1'b0;
      #1;
      n_checks++; if (a_s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b exp 1", a_s_ready); else n_pass++;
      n_checks++; if (a_m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b exp 0", a_m_valid); else n_pass++;
      n_checks++; if (a_level !== 3'd0) $display("FAIL reset_level: got %0d exp 0", a_level); else n_pass++;
      n_checks++; if (a_frame !== 1'b0) $display("FAIL reset_frame: got %b exp 0", a_frame); else n_pass++;
      n_checks++; if ({a_sof, a_eol, a_eof} !== 3'b000) $display("FAIL reset_tags: got %b exp 000", {a_sof, a_eol, a_eof}); else n_pass++;
      tick();
    end
    idle_inputs();
    rstn = 1'b1;
    tick();
  endtask

  // Eight pixels streamed through with the sink always ready.
  task automatic test_stream();
    for (int i = 0; i <= 8; i++) begin
      a_s_valid = (i < 8);
      a_s_data  = 24'(i + 1);
      a_m_ready = 1'b1;
      #1;
      if (i == 0) begin
        n_checks++; if (a_m_valid !== 1'b0) $display("FAIL stream_first_valid: got %b exp 0", a_m_valid); else n_pass++;
      end else begin
        n_checks++; if (a_m_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b exp 1", i, a_m_valid); else n_pass++;
        n_checks++; if (a_m_data !== 24'(i)) $display("FAIL stream_data[%0d]: got %h exp %h", i, a_m_data, 24'(i)); else n_pass++;
        n_checks++; if (a_sof !== (i == 1)) $display("FAIL stream_sof[%0d]: got %b exp %b", i, a_sof, (i == 1)); else n_pass++;
        n_checks++; if (a_eol !== (i == 4 || i == 8)) $display("FAIL stream_eol[%0d]: got %b exp %b", i, a_eol, (i == 4 || i == 8)); else n_pass++;
        n_checks++; if (a_eof !== (i == 8)) $display("FAIL stream_eof[%0d]: got %b exp %b", i, a_eof, (i == 8)); else n_pass++;
        n_checks++; if (a_frame !== 1'b0) $display("FAIL stream_frame_pre[%0d]: got %b exp 0", i, a_frame); else n_pass++;
        n_checks++; if (a_level !== 3'd1) $display("FAIL stream_level[%0d]: got %0d exp 1", i, a_level); else n_pass++;
      end
      tick();
    end
    a_s_valid = 1'b0; a_m_ready = 1'b0;
    #1;
    n_checks++; if (a_frame !== 1'b1) $display("FAIL stream_frame_post: got %b exp 1", a_frame); else n_pass++;
    n_checks++; if (a_m_valid !== 1'b0) $display("FAIL stream_empty: got %b exp 0", a_m_valid); else n_pass++;
    tick();
  endtask

  // Six pixels offered while the sink stalls, then drained in order.
  task automatic test_back_pressure();
    logic [23:0] pix[6];
    int sent;
    int popped;
    logic [23:0] exp_v;
    for (int k = 0; k < 6; k++) pix[k] = 24'h000010 + 24'(k);
    sent = 0;
    popped = 0;
    for (int j = 0; j < 6; j++) begin
      a_s_valid = 1'b1; a_s_data = pix[sent]; a_m_ready = 1'b0;
      #1;
      if (a_s_ready) begin exp_q.push_back(pix[sent]); sent++; end
      tick();
    end
    #1;
    n_checks++; if (sent != 4) $display("FAIL bp_accepted: got %0d exp 4", sent); else n_pass++;
    n_checks++; if (a_level !== 3'd4) $display("FAIL bp_level: got %0d exp 4", a_level); else n_pass++;
    n_checks++; if (a_s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b exp 0", a_s_ready); else n_pass++;
    n_checks++; if (a_m_data !== 24'h000010) $display("FAIL bp_head: got %h exp 000010", a_m_data); else n_pass++;
    for (int cyc = 0; cyc < 30 && popped < 6; cyc++) begin
      a_m_ready = 1'b1;
      a_s_valid = (sent < 6);
      a_s_data  = (sent < 6) ? pix[sent] : 24'h0;
      #1;
      if (cyc == 0) begin
        n_checks++; if (a_s_ready !== 1'b0) $display("FAIL bp_full_no_accept: got %b exp 0", a_s_ready); else n_pass++;
      end
      if (a_m_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        n_checks++; if (a_m_data !== exp_v) $display("FAIL bp_drain_data[%0d]: got %h exp %h", popped, a_m_data, exp_v); else n_pass++;
        n_checks++; if (a_sof !== (popped == 0)) $display("FAIL bp_drain_sof[%0d]: got %b exp %b", popped, a_sof, (popped == 0)); else n_pass++;
        n_checks++; if (a_eol !== (popped == 3)) $display("FAIL bp_drain_eol[%0d]: got %b exp %b", popped, a_eol, (popped == 3)); else n_pass++;
        popped++;
      end
      if (a_s_valid && a_s_ready) begin exp_q.push_back(pix[sent]); sent++; end
      tick();
    end
    a_s_valid = 1'b0; a_m_ready = 1'b0;
    #1;
    n_checks++; if (popped != 6) $display("FAIL bp_drain_count: got %0d exp 6", popped); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (a_level !== 3'd0) $display("FAIL bp_level_end: got %0d exp 0", a_level); else n_pass++;
    tick();
  endtask

  // Full buffer with push and pop both requested. Raster at x=2, y=1 here.
  task automatic test_full_simul();
    for (int k = 0; k < 4; k++) begin
      a_s_valid = 1'b1; a_s_data = 24'h000020 + 24'(k); a_m_ready = 1'b0;
      tick();
    end
    a_s_valid = 1'b1; a_s_data = 24'h000024; a_m_ready = 1'b1;
    #1;
    n_checks++; if (a_level !== 3'd4) $display("FAIL full_level_pre: got %0d exp 4", a_level); else n_pass++;
    n_checks++; if (a_s_ready !== 1'b0) $display("FAIL full_s_ready: got %b exp 0", a_s_ready); else n_pass++;
    n_checks++; if (a_m_data !== 24'h000020) $display("FAIL full_head: got %h exp 000020", a_m_data); else n_pass++;
    tick();
    n_checks++; if (a_level !== 3'd3) $display("FAIL full_level_pop_only: got %0d exp 3", a_level); else n_pass++;
    n_checks++; if (a_s_ready !== 1'b1) $display("FAIL full_s_ready_back: got %b exp 1", a_s_ready); else n_pass++;
    n_checks++; if (a_m_data !== 24'h000021) $display("FAIL full_head2: got %h exp 000021", a_m_data); else n_pass++;
    n_checks++; if (a_eof !== 1'b1) $display("FAIL full_eof: got %b exp 1", a_eof); else n_pass++;
    n_checks++; if (a_frame !== 1'b1) $display("FAIL full_frame_pre: got %b exp 1", a_frame); else n_pass++;
    tick();
    n_checks++; if (a_level !== 3'd3) $display("FAIL full_level_both: got %0d exp 3", a_level); else n_pass++;
    n_checks++; if (a_frame !== 1'b0) $display("FAIL full_frame_post: got %b exp 0", a_frame); else n_pass++;
    n_checks++; if (a_sof !== 1'b1) $display("FAIL full_sof: got %b exp 1", a_sof); else n_pass++;
    a_s_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      #1;
      n_checks++; if (a_m_data !== 24'h000020 + 24'(k)) $display("FAIL full_drain[%0d]: got %h exp %h", k, a_m_data, 24'h000020 + 24'(k)); else n_pass++;
      tick();
    end
    a_m_ready = 1'b0;
    #1;
    n_checks++; if (a_m_valid !== 1'b0) $display("FAIL full_drained: got %b exp 0", a_m_valid); else n_pass++;
    tick();
  endtask

  // Flush mid-line with push and pop requested in the same cycle.
  task automatic test_flush();
    int frame_before;
    for (int k = 0; k < 4; k++) begin
      a_s_valid = 1'b1; a_s_data = 24'h000030 + 24'(k); a_m_ready = 1'b0;
      tick();
    end
    a_s_valid = 1'b0; a_m_ready = 1'b1;
    #1;
    n_checks++; if (a_eol !== 1'b1) $display("FAIL flush_pre_eol: got %b exp 1", a_eol); else n_pass++;
    tick();
    a_s_valid = 1'b1; a_s_data = 24'h000034; a_m_ready = 1'b1;
    tick();
    a_flush = 1'b1; a_s_valid = 1'b1; a_s_data = 24'h000035; a_m_ready = 1'b1;
    #1;
    frame_before = int'(a_frame);
    n_checks++; if (a_level !== 3'd3) $display("FAIL flush_level_pre: got %0d exp 3", a_level); else n_pass++;
    n_checks++; if (a_s_ready !== 1'b0) $display("FAIL flush_s_ready: got %b exp 0", a_s_ready); else n_pass++;
    n_checks++; if (a_m_valid !== 1'b0) $display("FAIL flush_m_valid: got %b exp 0", a_m_valid); else n_pass++;
    n_checks++; if ({a_sof, a_eol, a_eof} !== 3'b000) $display("FAIL flush_tags: got %b exp 000", {a_sof, a_eol, a_eof}); else n_pass++;
    tick();
    a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
    #1;
    n_checks++; if (a_level !== 3'd0) $display("FAIL flush_level_post: got %0d exp 0", a_level); else n_pass++;
    n_checks++; if (int'(a_frame) != frame_before || a_frame !== 1'b0) $display("FAIL flush_frame: got %b exp 0", a_frame); else n_pass++;
    // Held flush keeps the block empty even with a pending push.
    a_flush = 1'b1; a_s_valid = 1'b1; a_s_data = 24'h000037;
    tick(); tick(); tick();
    a_flush = 1'b0; a_s_valid = 1'b0;
    #1;
    n_checks++; if (a_level !== 3'd0) $display("FAIL flush_held_level: got %0d exp 0", a_level); else n_pass++;
    a_s_valid = 1'b1; a_s_data = 24'h000036;
    tick();
    a_s_valid = 1'b0;
    #1;
    n_checks++; if (a_m_data !== 24'h000036) $display("FAIL flush_next_data: got %h exp 000036", a_m_data); else n_pass++;
    n_checks++; if (a_sof !== 1'b1) $display("FAIL flush_next_sof: got %b exp 1", a_sof); else n_pass++;
    a_m_ready = 1'b1;
    tick();
    a_m_ready = 1'b0;
  endtask

  // 1x1 raster: every pixel is sof, eol and eof; frame toggles per pixel.
  task automatic test_degenerate();
    for (int i = 0; i <= 3; i++) begin
      b_s_valid = (i < 3);
      b_s_data  = 24'h0000A0 + 24'(i);
      b_m_ready = 1'b1;
      #1;
      if (i > 0) begin
        n_checks++; if (b_m_data !== 24'h0000A0 + 24'(i - 1)) $display("FAIL degen_data[%0d]: got %h exp %h", i, b_m_data, 24'h0000A0 + 24'(i - 1)); else n_pass++;
        n_checks++; if ({b_sof, b_eol, b_eof} !== 3'b111) $display("FAIL degen_tags[%0d]: got %b exp 111", i, {b_sof, b_eol, b_eof}); else n_pass++;
        n_checks++; if (b_frame !== 1'((i - 1) % 2)) $display("FAIL degen_frame[%0d]: got %b exp %b", i, b_frame, 1'((i - 1) % 2)); else n_pass++;
      end
      tick();
    end
    b_s_valid = 1'b0; b_m_ready = 1'b0;
    #1;
    n_checks++; if (b_frame !== 1'b1) $display("FAIL degen_frame_end: got %b exp 1", b_frame); else n_pass++;
    b_s_valid = 1'b1; b_s_data = 24'h0000B0;
    tick();
    b_s_valid = 1'b0; b_flush = 1'b1;
    #1;
    n_checks++; if (b_m_valid !== 1'b0) $display("FAIL degen_flush_valid: got %b exp 0", b_m_valid); else n_pass++;
    tick();
    b_flush = 1'b0;
    #1;
    n_checks++; if (b_level !== 3'd0) $display("FAIL degen_flush_level: got %0d exp 0", b_level); else n_pass++;
    n_checks++; if (b_frame !== 1'b1) $display("FAIL degen_flush_frame: got %b exp 1", b_frame); else n_pass++;
    tick();
  endtask

  // Reset asserted between edges clears state immediately.
  task automatic test_reset_mid();
    a_s_valid = 1'b1; a_s_data = 24'h000050; a_m_ready = 1'b0;
    tick(); tick();
    a_s_valid = 1'b0;
    #1;
    n_checks++; if (a_level !== 3'd2) $display("FAIL rstmid_level_pre: got %0d exp 2", a_level); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (a_level !== 3'd0) $display("FAIL rstmid_level: got %0d exp 0", a_level); else n_pass++;
    n_checks++; if (a_m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b exp 0", a_m_valid); else n_pass++;
    n_checks++; if (a_s_ready !== 1'b1) $display("FAIL rstmid_ready: got %b exp 1", a_s_ready); else n_pass++;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_back_pressure();
    test_full_simul();
    test_flush();
    test_degenerate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
